// File: rtl/cpu_stage_4_memory.sv
// LC-3b memory stage: data-memory loads/stores (including indirect LDI/STI),
// pipeline stall generation and load condition-code feedback to execute.
package lc3b_types;
    typedef struct packed {
        logic [15:0] instruction;
        logic [15:0] pc;
        logic [15:0] alu_out;
        logic [15:0] calc_adrs_out;
        logic [15:0] sr2_data;
        logic [15:0] mem_data_out;
        logic        ld_cc;
        logic        ld_reg;
        logic [2:0]  dest;
    } pipeline_ctrl;
endpackage

module cpu_stage_4_memory
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_all,
    input  pipeline_ctrl      ctrl_d_in,
    output pipeline_ctrl      ctrl_d_out,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [1:0]        dmem_byte_enable,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_mem,
    output logic [2:0]        gencc_to_c,
    output logic              ld_cc_to_c,
    output logic [1:0]        dbg_state
);
    // Handshake: dmem_read/dmem_write are levels held until the cycle dmem_resp
    // is high (read data valid in that cycle); dmem_resp without a request is ignored.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS1 = 2'd1, ACCESS2 = 2'd2, HOLD = 2'd3} state_t;

    localparam logic [3:0] OP_LDR = 4'b0110, OP_LDB = 4'b0010, OP_LDI = 4'b1010, OP_TRAP = 4'b1111;
    localparam logic [3:0] OP_STR = 4'b0111, OP_STB = 4'b0011, OP_STI = 4'b1011;

    state_t            state_q, state_d;
    logic              gap_q;
    logic [ADDR_W-2:0] ind_word_q;
    logic [DATA_W-1:0] hold_q;
    pipeline_ctrl      ctrl_q, ctrl_d;
    logic [2:0]        gencc_q, gencc_d;

    logic [3:0]        opcode, out_opcode;
    logic              is_load, is_store, is_mem, is_ind, is_byte;
    logic [ADDR_W-1:0] base_addr;
    logic              done, ind_step, capture;
    logic [7:0]        rd_byte, st_byte;
    logic [DATA_W-1:0] load_val, result;

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])
            return 3'b100;
        else if (|v)
            return 3'b001;
        else
            return 3'b010;
    endfunction

    assign opcode    = ctrl_d_in.instruction[15:12];
    assign is_load   = (opcode == OP_LDR) || (opcode == OP_LDB) || (opcode == OP_LDI) || (opcode == OP_TRAP);
    assign is_store  = (opcode == OP_STR) || (opcode == OP_STB) || (opcode == OP_STI);
    assign is_mem    = is_load || is_store;
    assign is_ind    = (opcode == OP_LDI) || (opcode == OP_STI);
    assign is_byte   = (opcode == OP_LDB) || (opcode == OP_STB);
    assign base_addr = ADDR_W'(ctrl_d_in.calc_adrs_out);
    assign st_byte   = ctrl_d_in.sr2_data[7:0];

    // Address bit 0 picks the high byte; LDB sign-extends it.
    assign rd_byte  = base_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    assign load_val = is_byte ? {{(DATA_W-8){rd_byte[7]}}, rd_byte} : dmem_rdata;
    assign result   = is_load ? load_val : DATA_W'(ctrl_d_in.mem_data_out);

    always_comb begin
        state_d          = state_q;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        stall_mem        = 1'b0;
        done             = 1'b0;
        ind_step         = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE, ACCESS1: begin
                    if (!is_mem) begin
                        state_d = IDLE;
                    end else if (is_ind) begin
                        dmem_read        = 1'b1;
                        dmem_address     = {base_addr[ADDR_W-1:1], 1'b0};
                        dmem_byte_enable = 2'b11;
                        stall_mem        = 1'b1;
                        if (dmem_resp) begin
                            ind_step = 1'b1;
                            state_d  = ACCESS2;
                        end else begin
                            state_d = ACCESS1;
                        end
                    end else begin
                        dmem_read        = is_load;
                        dmem_write       = is_store;
                        dmem_byte_enable = 2'b11;
                        if (is_byte) begin
                            dmem_address = base_addr;
                            dmem_wdata   = DATA_W'({st_byte, st_byte});
                            if (is_store)
                                dmem_byte_enable = base_addr[0] ? 2'b10 : 2'b01;
                        end else begin
                            dmem_address = {base_addr[ADDR_W-1:1], 1'b0};
                            dmem_wdata   = DATA_W'(ctrl_d_in.sr2_data);
                        end
                        if (dmem_resp) begin
                            done = 1'b1;
                        end else begin
                            stall_mem = 1'b1;
                            state_d   = ACCESS1;
                        end
                    end
                end
                ACCESS2: begin
                    // First ACCESS2 cycle is a bubble so the read visibly drops between accesses.
                    stall_mem = 1'b1;
                    if (!gap_q) begin
                        dmem_read        = is_load;
                        dmem_write       = is_store;
                        dmem_address     = {ind_word_q, 1'b0};
                        dmem_byte_enable = 2'b11;
                        dmem_wdata       = DATA_W'(ctrl_d_in.sr2_data);
                        if (dmem_resp) begin
                            done      = 1'b1;
                            stall_mem = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_all)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (done)
                state_d = stall_all ? HOLD : IDLE;
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        gencc_d = gencc_q;
        capture = !stall_all && ((state_q == IDLE && !is_mem) || done || state_q == HOLD);
        if (capture) begin
            ctrl_d = ctrl_d_in;
            if (done)
                ctrl_d.mem_data_out = 16'(result);
            else if (state_q == HOLD)
                ctrl_d.mem_data_out = 16'(hold_q);
            gencc_d = cc_of(ctrl_d.mem_data_out);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_q      <= 1'b0;
            ind_word_q <= '0;
            hold_q     <= '0;
            ctrl_q     <= '0;
            gencc_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            gap_q   <= ind_step;
            ctrl_q  <= ctrl_d;
            gencc_q <= gencc_d;
            if (ind_step)
                ind_word_q <= dmem_rdata[ADDR_W-1:1];
            if (done && stall_all)
                hold_q <= result;
        end
    end

    assign out_opcode = ctrl_q.instruction[15:12];
    assign ctrl_d_out = ctrl_q;
    assign gencc_to_c = gencc_q;
    assign ld_cc_to_c = ctrl_q.ld_cc &&
                        ((out_opcode == OP_LDR) || (out_opcode == OP_LDB) || (out_opcode == OP_LDI));
    assign dbg_state  = state_q;

endmodule

// File: doc/cpu_stage_4_memory.md
Name: cpu_stage_4_memory

Overview:
Memory stage (D) of the LC-3b pipeline, directly downstream of execute (C). It consumes the execute pipeline register and performs data-memory accesses for LDR/LDB/LDI/STR/STB/STI/TRAP through a request/response handshake, including the two-access indirect forms. It stalls the pipeline while an access is outstanding and feeds load-generated condition codes back to execute. It drives the memory-stage pipeline register toward writeback.

Parameters:
ADDR_W, 16, data-memory address width
DATA_W, 16, data word width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
stall_all  in  1  global pipeline stall; includes stall_mem, OR'd externally
ctrl_d_in  in  pipeline_ctrl  execute pipeline register (instruction, calc_adrs_out, alu_out, sr2_data, ld_cc, ...)
ctrl_d_out  out  pipeline_ctrl  memory pipeline register to writeback; loads write mem_data_out (new lc3b_types field)
dmem_read  out  1  read request, level, held until dmem_resp
dmem_write  out  1  write request, level, held until dmem_resp
dmem_address  out  ADDR_W  access address
dmem_wdata  out  DATA_W  store data
dmem_byte_enable  out  2  byte lanes for writes
dmem_resp  in  1  access complete; read data valid same cycle
dmem_rdata  in  DATA_W  read data
stall_mem  out  1  memory access pending and not completing this cycle
gencc_to_c  out  3  NZP generated from load data
ld_cc_to_c  out  1  execute CC register loads gencc_to_c

Behaviour:
- Reset (async, rst_n=0): FSM->IDLE; dmem_read=dmem_write=0; dmem_byte_enable=2'b00; ctrl_d_out=nop; gencc_to_c=3'b000; ld_cc_to_c=0; indirect-address and hold registers cleared. Reset mid-access drops requests immediately; a later dmem_resp is ignored.
- Opcode classes (ctrl_d_in.instruction[15:12]): loads LDR 0110, LDB 0010, LDI 1010, TRAP 1111; stores STR 0111, STB 0011, STI 1011. All others are non-memory.
- Store data comes from ctrl_d_in.sr2_data. Address is ctrl_d_in.calc_adrs_out.
- FSM states: IDLE, ACCESS1, ACCESS2, HOLD.
- IDLE, non-memory op: no request; stall_mem=0; on !stall_all, ctrl_d_out<=ctrl_d_in. Zero added latency.
- IDLE, memory op: requests assert combinationally in the same cycle; enters ACCESS1.
- IDLE->ACCESS1 condition: stall_mem=1 unless dmem_resp=1 in that same cycle (zero-wait memory allowed, completes in 1 cycle).
- ACCESS1:
  - LDI/STI: issue a word read at calc_adrs_out. On dmem_resp, latch dmem_rdata as the indirect address and go to ACCESS2. dmem_read drops for at least one cycle between accesses.
  - All other memory ops: a single access completes on dmem_resp.
- ACCESS2: LDI reads, STI writes at the latched indirect address; completes on dmem_resp.
- Word accesses force dmem_address[0]=0; dmem_byte_enable=2'b11.
- LDB: selects byte addr[0] (1=high), sign-extends to 16 bits.
- STB: dmem_wdata={sr2_data[7:0],sr2_data[7:0]}; dmem_byte_enable=2'b01 (addr[0]=0) or 2'b10 (addr[0]=1).
- Completion cycle:
  - stall_mem=0.
  - If !stall_all: ctrl_d_out<=ctrl_d_in with mem_data_out=load result; FSM->IDLE.
  - If stall_all: result captured in hold register; FSM->HOLD; no re-issue.
- HOLD: no requests; stall_mem=0; on !stall_all, ctrl_d_out<=ctrl_d_in with held data; FSM->IDLE.
- CC feedback: gencc_to_c is registered with ctrl_d_out; N=100 if data[15], P=001 if nonzero, else Z=010. ld_cc_to_c=1 while ctrl_d_out holds an LDR/LDB/LDI with ld_cc=1; TRAP and stores never set it.
- stall_all while IDLE with a non-memory op: ctrl_d_out holds its value.
- dmem_resp while not requesting: ignored.

Test Plan:
- LDR, calc_adrs_out=0x1235, dmem_rdata=0x8001, resp after 3 cycles -> dmem_address=0x1234; stall_mem=1 for 3 cycles; mem_data_out=0x8001; gencc_to_c=100; ld_cc_to_c=1.
- LDB at 0x2001, rdata=0x7F80, zero-wait -> 1-cycle completion; stall_mem never 1; mem_data_out=0x007F; CC=001. Same at 0x2000 -> 0xFF80; CC=100.
- STB at 0x3001, sr2_data=0x00AB -> dmem_write=1; wdata=0xABAB; byte_enable=2'b10; ld_cc_to_c=0.
- LDI: calc_adrs_out=0x4000, first rdata=0x5000, second rdata=0x0000 -> second dmem_address=0x5000; read deasserted for ≥1 cycle between accesses; CC=010.
- Completion with stall_all=1 for 2 cycles -> FSM in HOLD; exactly one dmem_read transaction; ctrl_d_out updates once stall_all falls.
- rst_n pulled low during an STI second access -> dmem_write drops asynchronously; ctrl_d_out=nop; a late dmem_resp causes no state change.
